coin_acceptor: RTL and testbench

- Front-end stage of the vending machine. It sits directly upstream of the per-item vending FSMs and drives their nickel_in and dime_in inputs.
- Converts two raw, asynchronous, bouncy coin-sensor lines into clean single-cycle, mutually exclusive coin pulses.
- Rejects ambiguous coins (both sensors active) and coins inserted while the downstream FSM cannot accept them.
- Enforces release and lockout between coins so a single coin is never credited twice.

---
 rtl/vending_pkg.sv | 33 +++
 rtl/coin_sync.sv | 26 ++
 rtl/coin_acceptor.sv | 156 +++++++++++++++
 tb/tb_coin_acceptor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine front end: coin acceptor state
// encodings, coin values in nickel units and the common counter width.
package vending_pkg;

   // Width of the qualification / lockout counter inside the coin acceptor
   localparam int CNT_W = 8;

   // Coin values expressed in nickels
   localparam int NICKEL_VAL = 1;
   localparam int DIME_VAL   = 2;

   // One-hot coin acceptor states
   localparam logic [5:0] ST_IDLE         = 6'b000001;
   localparam logic [5:0] ST_QUAL         = 6'b000010;
   localparam logic [5:0] ST_EMIT         = 6'b000100;
   localparam logic [5:0] ST_REJECT       = 6'b001000;
   localparam logic [5:0] ST_WAIT_RELEASE = 6'b010000;
   localparam logic [5:0] ST_LOCKOUT      = 6'b100000;

   // Which sensor started the coin currently being qualified
   typedef enum logic {
      COIN_NICKEL = 1'b0,
      COIN_DIME   = 1'b1
   } coinType_e;

   // Saturating 16-bit add used by the statistics counters
   function automatic logic [15:0] satAdd16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchronizer for one raw coin sensor line, cleared by the
// synchronous reset so a coin held across reset starts from a known low.
module coin_sync (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   // Shift the raw level through two flops to settle metastability
   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the nickel and dime
// sensors, then emits one clean credit or reject pulse per coin, with release
// and lockout handling so a coin is never credited twice.
// Optional statistics outputs are enabled with COIN_ACCEPTOR_STATS_EN.
module coin_acceptor
   import vending_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        coin_nickel_raw,
   input  logic        coin_dime_raw,
   input  logic        accept_en,
   output logic        nickel_in,
   output logic        dime_in,
   output logic        coin_reject,
   output logic        busy
`ifdef COIN_ACCEPTOR_STATS_EN
   ,
   output logic [15:0] accepted_count,
   output logic [7:0]  reject_count
`endif
);

   localparam logic [CNT_W-1:0] DEB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCKOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic nsync;
   logic dsync;

   logic [5:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   coinType_e        coinType_q, coinType_d;

   logic latchedHigh;
   logic otherHigh;

   coin_sync uNickelSync (
      .clock   (clock),
      .reset   (reset),
      .async_i (coin_nickel_raw),
      .sync_o  (nsync)
   );

   coin_sync uDimeSync (
      .clock   (clock),
      .reset   (reset),
      .async_i (coin_dime_raw),
      .sync_o  (dsync)
   );

   assign latchedHigh = (coinType_q == COIN_DIME) ? dsync : nsync;
   assign otherHigh   = (coinType_q == COIN_DIME) ? nsync : dsync;

   // Next-state logic: qualify a single coin, then wait for release and lockout
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      coinType_d = coinType_q;
      case (state_q)
         ST_IDLE: begin
            if (nsync ^ dsync) begin
               coinType_d = dsync ? COIN_DIME : COIN_NICKEL;
               cnt_d      = CNT_ONE;
               state_d    = ST_QUAL;
            end else if (nsync && dsync) begin
               state_d = ST_REJECT;
            end
         end
         ST_QUAL: begin
            if (otherHigh) begin
               state_d = ST_REJECT;
            end else if (!latchedHigh) begin
               state_d = ST_IDLE;
            end else if (cnt_q == DEB_LIMIT) begin
               state_d = ST_EMIT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_EMIT: begin
            state_d = ST_WAIT_RELEASE;
         end
         ST_REJECT: begin
            state_d = ST_WAIT_RELEASE;
         end
         ST_WAIT_RELEASE: begin
            if (!nsync && !dsync) begin
               cnt_d   = CNT_ONE;
               state_d = ST_LOCKOUT;
            end
         end
         ST_LOCKOUT: begin
            if (nsync || dsync) begin
               state_d = ST_WAIT_RELEASE;
            end else if (cnt_q == LOCK_LIMIT) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_WAIT_RELEASE;
         end
      endcase
   end

   // State registers; reset parks in WAIT_RELEASE so a held coin is ignored
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_WAIT_RELEASE;
         cnt_q      <= '0;
         coinType_q <= COIN_NICKEL;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         coinType_q <= coinType_d;
      end
   end

   assign nickel_in   = (state_q == ST_EMIT) && accept_en && (coinType_q == COIN_NICKEL);
   assign dime_in     = (state_q == ST_EMIT) && accept_en && (coinType_q == COIN_DIME);
   assign coin_reject = (state_q == ST_REJECT) || ((state_q == ST_EMIT) && !accept_en);
   assign busy        = (state_q != ST_IDLE);

`ifdef COIN_ACCEPTOR_STATS_EN
   logic [15:0] accepted_q;
   logic [7:0]  reject_q;

   // Running totals of credited value (in nickels) and rejected coins, saturating
   always_ff @(posedge clock) begin
      if (reset) begin
         accepted_q <= '0;
         reject_q   <= '0;
      end else begin
         if (nickel_in) begin
            accepted_q <= satAdd16(accepted_q, 16'(NICKEL_VAL));
         end else if (dime_in) begin
            accepted_q <= satAdd16(accepted_q, 16'(DIME_VAL));
         end
         if (coin_reject && (reject_q != 8'hFF)) begin
            reject_q <= reject_q + 8'd1;
         end
      end
   end

   assign accepted_count = accepted_q;
   assign reject_count   = reject_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor. Expected pulses (kind and cycle) are
// queued as stimulus is applied and matched by a monitor on the falling edge.
module tb_coin_acceptor;

   localparam int KIND_NICKEL = 0;
   localparam int KIND_DIME   = 1;
   localparam int KIND_REJECT = 2;

   typedef struct {
      int kind;
      int cycle;
   } expEvent_t;

   logic clock = 1'b0;
   logic reset;
   logic coinNickelRaw;
   logic coinDimeRaw;
   logic acceptEn;
   logic nickelIn;
   logic dimeIn;
   logic coinReject;
   logic busy;
`ifdef COIN_ACCEPTOR_STATS_EN
   logic [15:0] acceptedCount;
   logic [7:0]  rejectCount;
`endif

   int testsRun   = 0;
   int failCount  = 0;
   int cycleCount = 0;
   int c;
   int c2;
   int monKind;
   expEvent_t monEv;
   expEvent_t expQ[$];

   coin_acceptor #(
      .DEBOUNCE_CYCLES (4),
      .LOCKOUT_CYCLES  (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .coin_nickel_raw (coinNickelRaw),
      .coin_dime_raw   (coinDimeRaw),
      .accept_en       (acceptEn),
      .nickel_in       (nickelIn),
      .dime_in         (dimeIn),
      .coin_reject     (coinReject),
      .busy            (busy)
`ifdef COIN_ACCEPTOR_STATS_EN
      ,
      .accepted_count  (acceptedCount),
      .reject_count    (rejectCount)
`endif
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Edge counter used to time expected pulses
   always @(posedge clock) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic nick, input logic dime, input logic acc);
      coinNickelRaw = nick;
      coinDimeRaw   = dime;
      acceptEn      = acc;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pushExpect(input int kind, input int cycle);
      expEvent_t ev;
      ev.kind  = kind;
      ev.cycle = cycle;
      expQ.push_back(ev);
   endtask

   // Monitor: every output pulse must match the oldest queued expectation
   always @(negedge clock) begin
      if (!reset && (nickelIn || dimeIn || coinReject)) begin
         checkOutput("pulse_onehot", int'(nickelIn) + int'(dimeIn) + int'(coinReject), 1);
         monKind = nickelIn ? KIND_NICKEL : (dimeIn ? KIND_DIME : KIND_REJECT);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_pulse", monKind, -1);
         end else begin
            monEv = expQ.pop_front();
            checkOutput("pulse_kind", monKind, monEv.kind);
            checkOutput("pulse_cycle", cycleCount, monEv.cycle);
         end
      end
   end

   // Absolute time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(3);
      checkOutput("reset_busy", int'(busy), 1);
      checkOutput("reset_nickel", int'(nickelIn), 0);
      checkOutput("reset_dime", int'(dimeIn), 0);
      checkOutput("reset_reject", int'(coinReject), 0);
      reset = 1'b0;
      waitCycles(8);
      checkOutput("idle_after_reset", int'(busy), 0);

      // Clean nickel held for 10 cycles
      c = cycleCount;
      applyStimulus(1'b1, 1'b0, 1'b1);
      pushExpect(KIND_NICKEL, c + 7);
      waitCycles(10);
      c2 = cycleCount;
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(4);
      checkOutput("clean_busy_lockout", int'(busy), 1);
      waitCycles(1);
      checkOutput("clean_busy_idle", int'(busy), 0);
      checkOutput("clean_drained", expQ.size(), 0);

      // Bounce: high 2, low 1, then stable high
      c = cycleCount;
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitCycles(2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      pushExpect(KIND_NICKEL, c + 10);
      waitCycles(10);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(8);
      checkOutput("bounce_drained", expQ.size(), 0);
      checkOutput("bounce_idle", int'(busy), 0);

      // Ambiguous coin: both sensors together
      c = cycleCount;
      applyStimulus(1'b1, 1'b1, 1'b1);
      pushExpect(KIND_REJECT, c + 3);
      waitCycles(8);
      checkOutput("ambig_held_busy", int'(busy), 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(8);
      checkOutput("ambig_drained", expQ.size(), 0);
      checkOutput("ambig_idle", int'(busy), 0);

      // Dime with downstream not ready
      c = cycleCount;
      applyStimulus(1'b0, 1'b1, 1'b0);
      pushExpect(KIND_REJECT, c + 7);
      waitCycles(10);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitCycles(8);
      acceptEn = 1'b1;
      checkOutput("notready_drained", expQ.size(), 0);
      checkOutput("notready_idle", int'(busy), 0);

      // Dime rises two cycles into nickel qualification
      c = cycleCount;
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitCycles(2);
      applyStimulus(1'b1, 1'b1, 1'b1);
      pushExpect(KIND_REJECT, c + 5);
      waitCycles(8);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(8);
      checkOutput("midqual_drained", expQ.size(), 0);
      checkOutput("midqual_idle", int'(busy), 0);

      // Reset during qualification with nickel still held
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitCycles(4);
      reset = 1'b1;
      waitCycles(1);
      reset = 1'b0;
      checkOutput("rst_qual_busy", int'(busy), 1);
      waitCycles(6);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(8);
      checkOutput("rst_qual_drained", expQ.size(), 0);
      checkOutput("rst_qual_idle", int'(busy), 0);

      // Nickel then dime after reset
      c = cycleCount;
      applyStimulus(1'b1, 1'b0, 1'b1);
      pushExpect(KIND_NICKEL, c + 7);
      waitCycles(10);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(8);
      c = cycleCount;
      applyStimulus(1'b0, 1'b1, 1'b1);
      pushExpect(KIND_DIME, c + 7);
      waitCycles(10);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(8);
      checkOutput("credit_drained", expQ.size(), 0);
`ifdef COIN_ACCEPTOR_STATS_EN
      checkOutput("accepted_count", int'(acceptedCount), 3);
      checkOutput("reject_count", int'(rejectCount), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
